// File: rtl/nrz_line_decoder_pkg.sv
// Shared bit-sync definitions: line-code encodings, RNRZ descrambler taps,
// decoder FSM states and the per-symbol line-decode function.
package bitsync_pkg;

  typedef enum logic [1:0] {
    CODE_NRZL  = 2'b00,
    CODE_NRZM  = 2'b01,
    CODE_NRZS  = 2'b10,
    CODE_NRZLI = 2'b11
  } code_sel_t;

  localparam int RNRZ_TAP_A = 13;
  localparam int RNRZ_TAP_B = 14;
  localparam int RNRZ_LEN   = 15;

  // FILL: no real previous symbol yet; RUN: prev_h holds channel data.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } dec_state_t;

  // Map hard decision h and the previous hard decision to a data bit.
  function automatic logic line_decode(input logic [1:0] sel, input logic h,
                                       input logic prev_h);
    logic d;
    d = h;
    case (sel)
      CODE_NRZL:  d = h;
      CODE_NRZM:  d = h ^ prev_h;
      CODE_NRZS:  d = ~(h ^ prev_h);
      CODE_NRZLI: d = ~h;
      default:    d = h;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/nrz_line_decoder_if.sv
// Symbol-in / bit-out bus of the NRZ line decoder.
// Handshake: nrz_en is a one-cycle strobe qualifying nrz_i/code_sel/derand_on;
// there is no back-pressure, the decoder accepts a symbol every cycle.
// data_en is a one-cycle strobe qualifying data_o, one clock after nrz_en.
// low_density/fault_cnt are levels; fsm_state exposes the decoder FSM.
interface nrz_line_decoder_if;
  import bitsync_pkg::*;

  logic       nrz_en;
  logic [2:0] nrz_i;
  logic [1:0] code_sel;
  logic       derand_on;
  logic       data_o;
  logic       data_en;
  logic       low_density;
  logic [7:0] fault_cnt;
  dec_state_t fsm_state;

  modport master (
    output nrz_en, nrz_i, code_sel, derand_on,
    input  data_o, data_en, low_density, fault_cnt, fsm_state
  );

  modport slave (
    input  nrz_en, nrz_i, code_sel, derand_on,
    output data_o, data_en, low_density, fault_cnt, fsm_state
  );
endinterface

// File: rtl/nrz_line_decoder_derand.sv
// Self-synchronizing RNRZ-L descrambler (x^15+x^14+1). Output is combinational
// from the current bit so the decoder adds no latency; history shifts on every
// enabled bit even when bypassed so it is in sync when switched on.
module rnrz_derandomizer
  import bitsync_pkg::*;
(
  input  logic clk,
  input  logic rs,
  input  logic en,
  input  logic d,
  input  logic bypass,
  output logic q
);

  logic [RNRZ_LEN-1:0] sr;

  // Shift register of received (scrambled) bits.
  always_ff @(posedge clk) begin
    if (rs) begin
      sr <= '0;
    end else if (en) begin
      sr <= {sr[RNRZ_LEN-2:0], d};
    end
  end

  assign q = bypass ? d : (d ^ sr[RNRZ_TAP_A] ^ sr[RNRZ_TAP_B]);

endmodule

// File: rtl/nrz_line_decoder.sv
// NRZ-L/M/S line decoder with channel transition-density monitor.
// Optional RNRZ-L descrambler after the line decode when RNRZ_DERAND_EN is defined.
module nrz_line_decoder
  import bitsync_pkg::*;
#(
  parameter int WIN_LEN   = 256,
  parameter int WIN_W     = 8,
  parameter int MIN_TRANS = 16
) (
  input  logic            clk,
  input  logic            rs,
  nrz_line_decoder_if.slave bus
);

  dec_state_t       state_q, state_d;
  logic             prev_h;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W:0]   trans_cnt;
  logic [WIN_W+1:0] total;
  logic             h, d_bit, bit_out, trans, win_end;
  logic             data_q, data_en_q, low_q;
  logic [7:0]       fault_q;

  assign h     = bus.nrz_i[2];
  assign d_bit = line_decode(bus.code_sel, h, prev_h);
  // In FILL prev_h is the reset value, not channel data, so no transition.
  assign trans   = (h ^ prev_h) & (state_q == ST_RUN);
  assign total   = {1'b0, trans_cnt} + {{(WIN_W+1){1'b0}}, trans};
  assign win_end = (win_cnt == WIN_W'(WIN_LEN - 1));

`ifdef RNRZ_DERAND_EN
  logic unused_soft;
  assign unused_soft = ^bus.nrz_i[1:0];

  rnrz_derandomizer u_derand (
    .clk    (clk),
    .rs     (rs),
    .en     (bus.nrz_en),
    .d      (d_bit),
    .bypass (~bus.derand_on),
    .q      (bit_out)
  );
`else
  logic unused_soft;
  assign unused_soft = ^{bus.nrz_i[1:0], bus.derand_on};
  assign bit_out     = d_bit;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rs) state_q <= ST_FILL;
    else    state_q <= state_d;
  end

  // FSM next state: first accepted symbol leaves FILL.
  always_comb begin
    state_d = state_q;
    if (bus.nrz_en && state_q == ST_FILL) state_d = ST_RUN;
  end

  // Decoded bit output register and symbol history.
  always_ff @(posedge clk) begin
    if (rs) begin
      data_q    <= 1'b0;
      data_en_q <= 1'b0;
      prev_h    <= 1'b0;
    end else begin
      data_en_q <= bus.nrz_en;
      if (bus.nrz_en) begin
        data_q <= bit_out;
        prev_h <= h;
      end
    end
  end

  // Transition-density window: count, then judge on the window's last symbol.
  always_ff @(posedge clk) begin
    if (rs) begin
      win_cnt   <= '0;
      trans_cnt <= '0;
      low_q     <= 1'b0;
      fault_q   <= 8'd0;
    end else if (bus.nrz_en) begin
      if (win_end) begin
        win_cnt   <= '0;
        trans_cnt <= '0;
        low_q     <= (total < (WIN_W+2)'(MIN_TRANS));
        if (total < (WIN_W+2)'(MIN_TRANS) && fault_q != 8'hFF) begin
          fault_q <= fault_q + 8'd1;
        end
      end else begin
        win_cnt <= win_cnt + 1'b1;
        if (trans && trans_cnt != '1) trans_cnt <= trans_cnt + 1'b1;
      end
    end
  end

  assign bus.data_o      = data_q;
  assign bus.data_en     = data_en_q;
  assign bus.low_density = low_q;
  assign bus.fault_cnt   = fault_q;
  assign bus.fsm_state   = state_q;

endmodule
